// File: rtl/rr_distributor_pkg.sv
// rr_distributor_pkg
// Shared types and helpers for the round-robin distributor.
//   state_e  : lock FSM states (IDLE = free to pick, LOCKED = target frozen)
//   next_idx : pointer increment with an explicit wrap at num-1, so that
//              channel counts that are not a power of two wrap correctly.
package rr_distributor_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Successor of idx in the ring 0..num-1.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned num);
    return (idx == num - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_dist_sel.sv
// rr_dist_sel
// Combinational masked rotate-priority pick: returns the first index at or
// after i_rr (wrapping modulo NumOut) whose i_mask bit is set.
// Ports:
//   i_rr    [IdxWidth]  rotation start pointer
//   i_mask  [NumOut]    eligible channels
//   o_idx   [IdxWidth]  chosen channel (equals i_rr when none is eligible)
//   o_found [1]         at least one channel eligible
module rr_dist_sel #(
  parameter int unsigned NumOut   = 4,
  parameter int unsigned IdxWidth = $clog2(NumOut)
) (
  input  logic [IdxWidth-1:0] i_rr,
  input  logic [NumOut-1:0]   i_mask,
  output logic [IdxWidth-1:0] o_idx,
  output logic                o_found
);

  // Walk the ring starting at i_rr; the first eligible hit wins and later
  // hits are ignored once o_found is set.
  always_comb begin
    int unsigned w_j;
    logic        w_hit;
    o_idx   = i_rr;
    o_found = 1'b0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      w_j     = int'(i_rr) + k;
      w_j     = (w_j >= NumOut) ? (w_j - NumOut) : w_j;
      w_hit   = i_mask[w_j] & ~o_found;
      o_idx   = w_hit ? IdxWidth'(w_j) : o_idx;
      o_found = o_found | i_mask[w_j];
    end
  end

endmodule

// File: rtl/rr_distributor.sv
// rr_distributor
// Round-robin dispatcher: one valid/ready input stream is handed item by item
// to NumOut output channels in strict rotating order, skipping masked
// channels. A lock FSM freezes the chosen target while that output stalls.
// Optional build macro RR_DISTRIBUTOR_OUT_REG_EN inserts a one-entry output
// register (1-cycle latency, full throughput); the lock FSM is then unused
// because the register itself freezes the target.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (pointer to 0, drop lock)
//   en_i    global enable        mask_i  per-channel eligibility
//   valid_i/ready_o/data_i       input stream
//   valid_o/ready_i/data_o       output channels (data broadcast)
//   idx_o   current target channel
module rr_distributor
  import rr_distributor_pkg::*;
#(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = $clog2(NumOut)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 en_i,
  input  logic [NumOut-1:0]    mask_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic [NumOut-1:0]    valid_o,
  input  logic [NumOut-1:0]    ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [IdxWidth-1:0]  idx_o
);

  localparam logic [NumOut-1:0] OneHot0 = {{(NumOut-1){1'b0}}, 1'b1};

  logic [IdxWidth-1:0] r_rr;
  logic [IdxWidth-1:0] w_pick_idx;
  logic                w_pick_found;

  rr_dist_sel #(
    .NumOut  (NumOut),
    .IdxWidth(IdxWidth)
  ) u_sel (
    .i_rr   (r_rr),
    .i_mask (mask_i),
    .o_idx  (w_pick_idx),
    .o_found(w_pick_found)
  );

`ifdef RR_DISTRIBUTOR_OUT_REG_EN

  logic                 r_full;
  logic [IdxWidth-1:0]  r_tgt;
  logic [DataWidth-1:0] r_data;
  logic                 w_drain;
  logic                 w_accept;

  // Output slot frees when its channel takes the item; a new item may enter
  // in the same cycle, giving one item per cycle with a ready target.
  always_comb begin
    w_drain  = r_full & en_i & ready_i[r_tgt];
    w_accept = valid_i & en_i & w_pick_found & (~r_full | w_drain) & ~flush_i & ~rst_i;
    valid_o  = (r_full & en_i & ~rst_i) ? (OneHot0 << r_tgt) : {NumOut{1'b0}};
    ready_o  = w_accept;
    data_o   = r_data;
    if (rst_i) begin
      idx_o = {IdxWidth{1'b0}};
    end else if (r_full) begin
      idx_o = r_tgt;
    end else begin
      idx_o = w_pick_found ? w_pick_idx : r_rr;
    end
  end

  // Pointer and output-register update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr   <= {IdxWidth{1'b0}};
      r_full <= 1'b0;
      r_tgt  <= {IdxWidth{1'b0}};
      r_data <= {DataWidth{1'b0}};
    end else if (flush_i) begin
      r_rr   <= {IdxWidth{1'b0}};
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_rr   <= IdxWidth'(next_idx(32'(w_pick_idx), NumOut));
      r_full <= 1'b1;
      r_tgt  <= w_pick_idx;
      r_data <= data_i;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

`else

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IdxWidth-1:0] r_sel;
  logic [IdxWidth-1:0] w_sel_nxt;
  logic [IdxWidth-1:0] w_rr_nxt;
  logic [IdxWidth-1:0] w_target;
  logic                w_exists;
  logic                w_valid_any;

  // Target choice, outputs and next-state. In LOCKED the mask is ignored so
  // a stalled item never migrates to another channel. valid_o is built
  // without ready_i; only ready_o and the state update look at ready_i.
  always_comb begin
    w_target    = (r_state == LOCKED) ? r_sel : w_pick_idx;
    w_exists    = (r_state == LOCKED) ? 1'b1 : w_pick_found;
    w_valid_any = valid_i & en_i & w_exists & ~rst_i;
    valid_o     = w_valid_any ? (OneHot0 << w_target) : {NumOut{1'b0}};
    ready_o     = w_valid_any & ready_i[w_target];
    data_o      = data_i;
    if (rst_i) begin
      idx_o = {IdxWidth{1'b0}};
    end else begin
      idx_o = w_exists ? w_target : r_rr;
    end

    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (w_valid_any & ~ready_o) begin
          w_state_nxt = LOCKED;
          w_sel_nxt   = w_target;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCKED: begin
        // Disabled cycles keep the lock; valid_o is simply gated off.
        if (ready_o) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (ready_o) begin
      w_rr_nxt = IdxWidth'(next_idx(32'(w_target), NumOut));
    end else begin
      w_rr_nxt = r_rr;
    end

    // Flush wins over the pointer update but a same-cycle handshake stands.
    if (flush_i) begin
      w_rr_nxt    = {IdxWidth{1'b0}};
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr    <= {IdxWidth{1'b0}};
      r_state <= IDLE;
      r_sel   <= {IdxWidth{1'b0}};
    end else begin
      r_rr    <= w_rr_nxt;
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

`endif

endmodule

// File: doc/rr_distributor.md
Name: rr_distributor

Overview:
- Round-robin dispatcher; the opposite direction of the common-cells round-robin arbiter.
- Takes one valid/ready input stream and hands each item to exactly one of NumOut output channels, in strict rotating order, skipping masked channels.
- Used to spread requests across replicated units: cache banks, FPU lanes, AXI ID workers.
- Includes a lock-in FSM so the chosen target stays stable while an output stalls.

Parameters:
- NumOut, 4: number of output channels, >= 2, need not be a power of two.
- DataWidth, 32: payload width.
- IdxWidth, $clog2(NumOut): derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  return pointer to 0 and drop the lock.
- en_i  in  1  global enable; when low, no handshake occurs.
- mask_i  in  NumOut  per-channel eligibility; 1 = may receive.
- valid_i  in  1  input item valid.
- ready_o  out  1  input item accepted this cycle.
- data_i  in  DataWidth  input payload.
- valid_o  out  NumOut  one-hot or zero output valid.
- ready_i  in  NumOut  per-channel ready.
- data_o  out  DataWidth  payload, broadcast to all channels.
- idx_o  out  IdxWidth  current target channel.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - rr_q=0, state=IDLE, sel_q=0.
  - valid_o=0, ready_o=0, idx_o=0 while reset is held.
  - Reset mid-transfer drops the pending item without a handshake.
- Target selection in IDLE:
  - Target = first index i at or after rr_q, wrapping modulo NumOut, with mask_i[i]=1.
  - If mask_i=0: no target, valid_o=0, ready_o=0, idx_o=rr_q.
- Target selection in LOCKED: target = sel_q; mask_i is ignored until the handshake.
- Output signals:
  - valid_o[target] = valid_i & en_i & target_exists; all other bits are 0.
  - ready_o = valid_o[target] & ready_i[target].
  - data_o = data_i, combinational, zero latency.
  - valid_o never depends on ready_i (no comb path ready_i -> valid_o).
- Handshake (valid_o[target] & ready_i[target]):
  - rr_q <= target+1, wrapping to 0 when target=NumOut-1; explicit compare, not power-of-two overflow.
  - State goes to IDLE.
- FSM:
  - IDLE -> LOCKED when valid_o is asserted without ready; sel_q <= target.
  - LOCKED -> IDLE on handshake.
  - LOCKED persists while en_i=0. valid_o drops meanwhile, matching the arbiter's enable gating.
- flush_i:
  - Next cycle rr_q=0, state=IDLE.
  - A handshake in the same cycle still completes; flush overrides the pointer update.
- Throughput: one item per cycle when the target is ready. Fairness: each unmasked channel gets at most one item per rotation.

Optional Feature:
- Macro RR_DISTRIBUTOR_OUT_REG_EN.
- Defined:
  - One-entry output register holds data, target and full flag; valid_o[tgt_q] = full_q.
  - Input accepted when en_i & target_exists & (~full_q | ready_i[tgt_q]).
  - rr_q advances on input acceptance. Latency 1 cycle, full throughput.
  - The lock FSM is bypassed because the register already freezes the target.
  - flush_i also clears full_q.
- Undefined: zero-latency combinational path as described above.
- The ports are identical in both builds.

Decomposition:
- rr_distributor_pkg:
  - state_e enum {IDLE, LOCKED}.
  - function next_idx(idx, num) for the modulo wrap.
- Sub-module rr_dist_sel: combinational masked rotate-priority pick. Inputs rr, mask; outputs idx, found.

Test Plan:
- NumOut=4, mask=4'b1111, all ready, valid_i held for 6 cycles -> targets 0,1,2,3,0,1 with one handshake per cycle; rr_q=2 at end.
- mask=4'b1010, rr_q=0 -> items go to 1,3,1; channels 0 and 2 never see valid_o.
- Target 2 with ready_i[2]=0 for 3 cycles while mask changes to 4'b0001 -> valid_o stays 4'b0100, data_o stays stable; handshake on ready, then next target is 0.
- NumOut=3 wrap: targets 0,1,2,0 -> rr_q never reaches 3.
- flush_i with handshake on channel 1 -> item delivered to 1, next item goes to 0; rst_i in LOCKED -> valid_o=0 next cycle, rr_q=0.
- RR_DISTRIBUTOR_OUT_REG_EN defined, same stream as test 1 -> identical target order, each item 1 cycle later, no bubbles.
